// File: rtl/issue_queue_pkg.sv
// Shared types and opcode helpers for the issue queue.
// Field widths are sized for PREG_W <= 8, IMM_W <= 32, NUM_FU <= 16.
package issue_queue_pkg;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_S  = 7'b0100011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;

    localparam int PREG_MAX = 8;
    localparam int IMM_MAX  = 32;
    localparam int FU_IDX_W = 4;

    typedef struct packed {
        logic                valid;
        logic [6:0]          opcode;
        logic [2:0]          alu_op;
        logic [PREG_MAX-1:0] rd;
        logic [PREG_MAX-1:0] rs1;
        logic [PREG_MAX-1:0] rs2;
        logic                rdy1;
        logic                rdy2;
        logic [IMM_MAX-1:0]  imm;
        logic [FU_IDX_W-1:0] fu;
    } iq_entry_t;

    function automatic logic needs_rs2(input logic [6:0] op);
        return (op == OP_R) || (op == OP_S);
    endfunction

    function automatic logic is_mem(input logic [6:0] op);
        return (op == OP_LD) || (op == OP_S);
    endfunction

    function automatic logic is_alloc(input logic [6:0] op);
        return needs_rs2(op) || (op == OP_I) || (op == OP_LD);
    endfunction

endpackage

// File: rtl/iq_pick_lowest.sv
// One-hot lowest-set-bit picker.
// Ports: req (request vector), onehot (lowest set bit of req), found (|req).
module iq_pick_lowest #(
    parameter int N = 8
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] onehot,
    output logic         found
);
    // Two's complement isolates the lowest set bit.
    assign onehot = req & (~req + N'(1));
    assign found  = |req;
endmodule

// File: rtl/issue_queue.sv
// Issue queue: holds renamed ops, wakes sources from the CDB and issues one
// ready op per FU per cycle, lowest index first. FU NUM_FU-1 is memory.
// Ports: disp_* dispatch bundle (valid/ready), cdb_* wakeup, fu_ready and
// registered issue_* per FU, flush, count/full occupancy.
// Optional: define ISSUE_QUEUE_PERF_EN for perf_full_cycles / perf_issued.
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int DISP_W = 2,
    parameter int NUM_FU = 3,
    parameter int CDB_W  = 2,
    parameter int PREG_W = 6,
    parameter int IMM_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DISP_W-1:0]          disp_valid,
    output logic                       disp_ready,
    input  logic [DISP_W*7-1:0]        disp_opcode,
    input  logic [DISP_W*3-1:0]        disp_alu_op,
    input  logic [DISP_W*PREG_W-1:0]   disp_rd,
    input  logic [DISP_W*PREG_W-1:0]   disp_rs1,
    input  logic [DISP_W*PREG_W-1:0]   disp_rs2,
    input  logic [DISP_W-1:0]          disp_rs1_rdy,
    input  logic [DISP_W-1:0]          disp_rs2_rdy,
    input  logic [DISP_W*IMM_W-1:0]    disp_imm,
    input  logic [CDB_W-1:0]           cdb_valid,
    input  logic [CDB_W*PREG_W-1:0]    cdb_tag,
    input  logic [NUM_FU-1:0]          fu_ready,
    output logic [NUM_FU-1:0]          issue_valid,
    output logic [NUM_FU*7-1:0]        issue_opcode,
    output logic [NUM_FU*3-1:0]        issue_alu_op,
    output logic [NUM_FU*PREG_W-1:0]   issue_rd,
    output logic [NUM_FU*PREG_W-1:0]   issue_rs1,
    output logic [NUM_FU*PREG_W-1:0]   issue_rs2,
    output logic [NUM_FU*IMM_W-1:0]    issue_imm,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full
`ifdef ISSUE_QUEUE_PERF_EN
    ,
    output logic [31:0]                perf_full_cycles,
    output logic [31:0]                perf_issued
`endif
);

    localparam int CW   = $clog2(DEPTH+1);
    localparam int NALU = NUM_FU - 1;

    iq_entry_t q     [DEPTH];
    iq_entry_t q_nxt [DEPTH];
    iq_entry_t sel_e [NUM_FU];

    logic [FU_IDX_W-1:0] rr, rr_nxt;
    logic [CW-1:0]       alloc_n, issue_n;
    logic [DEPTH-1:0]    valid_vec, clr;
    logic [DEPTH-1:0]    free_mask [DISP_W];
    logic [DEPTH-1:0]    slot_oh   [DISP_W];
    logic [DISP_W-1:0]   slot_found;
    logic [DEPTH-1:0]    sel_req   [NUM_FU];
    logic [DEPTH-1:0]    sel_oh    [NUM_FU];
    logic [NUM_FU-1:0]   sel_found, fire;

    function automatic logic cdb_hit(input logic [PREG_W-1:0] t);
        logic h;
        h = 1'b0;
        for (int c = 0; c < CDB_W; c++)
            h |= cdb_valid[c] && (cdb_tag[c*PREG_W +: PREG_W] == t);
        return h;
    endfunction

    assign disp_ready = (DEPTH - int'(count)) >= DISP_W;
    assign full       = (count == CW'(DEPTH));

    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            valid_vec[i] = q[i].valid;
    end

    // Slot j takes the j-th lowest free index: each picker masks off the
    // indices already claimed by lower slots.
    for (genvar j = 0; j < DISP_W; j++) begin : g_alloc
        if (j == 0) begin : g_first
            assign free_mask[j] = ~valid_vec;
        end else begin : g_next
            assign free_mask[j] = free_mask[j-1] & ~slot_oh[j-1];
        end
        iq_pick_lowest #(.N(DEPTH)) u_free (
            .req    (free_mask[j]),
            .onehot (slot_oh[j]),
            .found  (slot_found[j])
        );
    end

    always_comb begin
        for (int k = 0; k < NUM_FU; k++)
            for (int i = 0; i < DEPTH; i++)
                sel_req[k][i] = q[i].valid && q[i].rdy1 && q[i].rdy2 &&
                                (q[i].fu == FU_IDX_W'(k));
    end

    for (genvar k = 0; k < NUM_FU; k++) begin : g_sel
        iq_pick_lowest #(.N(DEPTH)) u_sel (
            .req    (sel_req[k]),
            .onehot (sel_oh[k]),
            .found  (sel_found[k])
        );
    end

    always_comb begin
        iq_entry_t ne;
        logic [6:0] op;
        ne      = '0;
        op      = '0;
        q_nxt   = q;
        rr_nxt  = rr;
        alloc_n = '0;
        issue_n = '0;
        clr     = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            sel_e[k] = '0;
            for (int i = 0; i < DEPTH; i++)
                if (sel_oh[k][i]) sel_e[k] = q[i];
            fire[k] = sel_found[k] && fu_ready[k];
            if (fire[k]) begin
                clr     = clr | sel_oh[k];
                issue_n = issue_n + CW'(1);
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (q[i].valid) begin
                if (cdb_hit(PREG_W'(q[i].rs1))) q_nxt[i].rdy1 = 1'b1;
                if (cdb_hit(PREG_W'(q[i].rs2))) q_nxt[i].rdy2 = 1'b1;
            end
            if (clr[i]) q_nxt[i].valid = 1'b0;
        end
        // Allocation only targets entries free in registered state, so it
        // never collides with entries freed by issue this cycle.
        for (int j = 0; j < DISP_W; j++) begin
            op = disp_opcode[j*7 +: 7];
            if (disp_valid[j] && disp_ready && slot_found[j] && is_alloc(op)) begin
                ne.valid  = 1'b1;
                ne.opcode = op;
                ne.alu_op = disp_alu_op[j*3 +: 3];
                ne.rd     = PREG_MAX'(disp_rd[j*PREG_W +: PREG_W]);
                ne.rs1    = PREG_MAX'(disp_rs1[j*PREG_W +: PREG_W]);
                ne.rs2    = PREG_MAX'(disp_rs2[j*PREG_W +: PREG_W]);
                ne.imm    = IMM_MAX'(disp_imm[j*IMM_W +: IMM_W]);
                ne.rdy1   = disp_rs1_rdy[j] ||
                            cdb_hit(disp_rs1[j*PREG_W +: PREG_W]);
                ne.rdy2   = !needs_rs2(op) || disp_rs2_rdy[j] ||
                            cdb_hit(disp_rs2[j*PREG_W +: PREG_W]);
                if (is_mem(op)) begin
                    ne.fu = FU_IDX_W'(NUM_FU - 1);
                end else begin
                    ne.fu  = rr_nxt;
                    rr_nxt = (int'(rr_nxt) == NALU - 1) ? '0
                                                        : rr_nxt + FU_IDX_W'(1);
                end
                for (int i = 0; i < DEPTH; i++)
                    if (slot_oh[j][i]) q_nxt[i] = ne;
                alloc_n = alloc_n + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
            count        <= '0;
            rr           <= '0;
            issue_valid  <= '0;
            issue_opcode <= '0;
            issue_alu_op <= '0;
            issue_rd     <= '0;
            issue_rs1    <= '0;
            issue_rs2    <= '0;
            issue_imm    <= '0;
        end else if (flush) begin
            // Round-robin pointer deliberately survives a flush.
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
            count       <= '0;
            issue_valid <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) q[i] <= q_nxt[i];
            count       <= count + alloc_n - issue_n;
            rr          <= rr_nxt;
            issue_valid <= fire;
            for (int k = 0; k < NUM_FU; k++) begin
                if (fire[k]) begin
                    issue_opcode[k*7 +: 7]           <= sel_e[k].opcode;
                    issue_alu_op[k*3 +: 3]           <= sel_e[k].alu_op;
                    issue_rd[k*PREG_W +: PREG_W]     <= PREG_W'(sel_e[k].rd);
                    issue_rs1[k*PREG_W +: PREG_W]    <= PREG_W'(sel_e[k].rs1);
                    issue_rs2[k*PREG_W +: PREG_W]    <= PREG_W'(sel_e[k].rs2);
                    issue_imm[k*IMM_W +: IMM_W]      <= IMM_W'(sel_e[k].imm);
                end
            end
        end
    end

`ifdef ISSUE_QUEUE_PERF_EN
    logic [32:0] pi_sum;

    always_comb begin
        pi_sum = {1'b0, perf_issued} + 33'(flush ? '0 : issue_n);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_full_cycles <= '0;
            perf_issued      <= '0;
        end else begin
            if ((|disp_valid) && !disp_ready && (perf_full_cycles != '1))
                perf_full_cycles <= perf_full_cycles + 32'd1;
            perf_issued <= pi_sum[32] ? '1 : pi_sum[31:0];
        end
    end
`endif

endmodule

// File: doc/issue_queue.md
Name: issue_queue

Overview:
- Parametrised successor to the single-table reservation station: holds renamed micro-ops after dispatch and tracks per-source readiness.
- Wakes sources from CDB broadcasts and issues one ready op per functional unit per cycle, lowest-index-first.
- Sits between rename/dispatch and the FU array (ALUs plus one memory unit).
- Adds a valid/ready dispatch handshake, flush, explicit occupancy and configurable depth, width and FU count.

Parameters:
DEPTH, 32, number of entries (power of two, >= DISP_W)
DISP_W, 2, dispatch slots per cycle
NUM_FU, 3, functional units; FU NUM_FU-1 is memory, 0..NUM_FU-2 are ALUs (NUM_FU >= 2)
CDB_W, 2, wakeup broadcast ports
PREG_W, 6, physical register tag width
IMM_W, 32, immediate width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
disp_valid  in  DISP_W  slot j carries an op
disp_ready  out  1  all DISP_W slots are accepted this cycle
disp_opcode  in  DISP_W*7  opcode per slot
disp_alu_op  in  DISP_W*3  ALU function per slot
disp_rd  in  DISP_W*PREG_W  destination tag
disp_rs1 / disp_rs2  in  DISP_W*PREG_W  source tags
disp_rs1_rdy / disp_rs2_rdy  in  DISP_W  source ready per the busy table
disp_imm  in  DISP_W*IMM_W  immediate
cdb_valid  in  CDB_W  broadcast valid
cdb_tag  in  CDB_W*PREG_W  completed destination tag
fu_ready  in  NUM_FU  FU k accepts an op this cycle
issue_valid  out  NUM_FU  registered; op presented to FU k
issue_opcode / issue_alu_op / issue_rd / issue_rs1 / issue_rs2 / issue_imm  out  NUM_FU*field  registered op fields per FU
flush  in  1  synchronous squash of all entries
count  out  $clog2(DEPTH+1)  occupied entries
full  out  1  count == DEPTH

Behaviour:
- Reset: all entries invalid, count=0, issue_valid=0, all issue fields 0, ALU round-robin pointer=0.
- Entry contents: valid, opcode, alu_op, rd, rs1, rs2, rdy1, rdy2, imm, fu index.
- Opcode classes:
  - 0110011 and 0100011 need rs1 and rs2.
  - 0010011 and 0000011 need rs1 only; rdy2 is forced to 1 at allocation.
  - Any other opcode: accepted but not allocated (treated as a NOP).
- disp_ready = (DEPTH - count) >= DISP_W, computed from registered count only; same-cycle issue never raises it.
- Dispatch occurs when disp_valid[j] && disp_ready. Slot j takes the j-th lowest free index.
- FU assignment:
  - 0000011 and 0100011 go to FU NUM_FU-1.
  - ALU ops take the round-robin pointer value, which then advances mod (NUM_FU-1). Slots are processed in index order, so two ALU ops in one cycle get consecutive ALUs.
- Wakeup:
  - Every valid entry source whose tag equals any valid cdb_tag sets its rdy bit at the clock edge.
  - Same-edge CDB bypass into dispatching slots is mandatory: a matching CDB tag sets the rdy bit at allocation.
- Selection is combinational from registered state. For each FU k, pick the lowest-index valid entry with fu==k && rdy1 && rdy2.
- Issue handshake:
  - The pick is issued only if fu_ready[k]=1. The issue output registers load at the edge and the entry is freed at the same edge.
  - If fu_ready[k]=0, issue_valid[k]=0 next cycle and the entry stays.
- Latency: an op dispatched at edge n with ready sources appears on issue_valid at edge n+1. A source woken by CDB at edge n issues at edge n+1 at earliest.
- Entries allocated in a cycle are never selected in that same cycle.
- count next = count + allocated - issued. Full and non-full states are reached by the same rule.
- Flush (priority over dispatch and issue):
  - All entries are invalidated and issue_valid is cleared at the edge; count becomes 0.
  - The round-robin pointer is kept.
  - Dispatch in the flush cycle is dropped.
- Reset asserted mid-operation clears state immediately (asynchronous); outputs return to reset values.

Optional Feature:
- Macro: ISSUE_QUEUE_PERF_EN.
- Defined:
  - Adds outputs perf_full_cycles [31:0], which increments each cycle disp_valid!=0 && !disp_ready.
  - Adds perf_issued [31:0], which adds popcount(issued) each cycle.
  - Both counters saturate at all-ones and clear on rst only.
- Undefined: the ports and counters are absent and the rest of the behaviour is identical.

Decomposition:
- Package issue_queue_pkg:
  - Opcode constants OP_R=7'b0110011, OP_S=7'b0100011, OP_I=7'b0010011, OP_LD=7'b0000011.
  - Packed struct iq_entry_t.
  - Function needs_rs2(opcode) and function is_mem(opcode).
- Sub-module iq_pick_lowest (parameter N): a one-hot lowest-set-bit picker with a found flag. It is instantiated once per FU for selection and reused for free-slot allocation.

Test Plan:
- Reset then dispatch ADD rd=10, rs1=1, rs2=2, both rdy, fu_ready=3'b111 -> issue_valid[0]=1 one cycle later with rd=10, count returns to 0.
- Dispatch LW rs1=5 not ready; CDB tag 5 two cycles later -> issue_valid[2]=1 with opcode 0000011 exactly one cycle after the CDB edge, and rs2 is ignored.
- Same-cycle bypass: dispatch ADDI rs1=7 not ready while cdb_tag=7 is valid -> issues the next cycle.
- Fill: DEPTH=32 with all sources not ready, 16 dual dispatches -> count=32, full=1, disp_ready=0. At count=31, disp_ready=0 because DISP_W=2.
- Two ready ALU ops dispatched together -> issue on FU0 and FU1 in the same cycle. With fu_ready[0]=0, the FU0 op is held and issues the cycle fu_ready[0]=1.
- Flush with count=5 and a simultaneous dispatch -> count=0 and issue_valid=0 next cycle, and no entry from the dispatch cycle survives.
